// File: rtl/zimbo_boot_loader.sv
// Serial image loader for the Zimbo core: parses SYNC/count/words/csum frames from
// the UART byte stream, writes words to the load port, then releases the core reset.
module zimbo_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned TIMEOUT   = 100000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        ld_we,
  output logic [15:0] ld_addr,
  output logic [15:0] ld_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CNT_HI  = 3'd1,
    S_CNT_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_RUN     = 3'd6
  } state_t;

  state_t        state_r, state_next_s;
  logic [15:0]   count_r, ld_addr_r, ld_wdata_r, words_loaded_r;
  logic [7:0]    sum_r, hi_r, csum_s;
  logic [TW-1:0] timer_r;
  logic          ld_we_r, cpu_reset_n_r, busy_r, error_r;
  logic          start_s, add_s, write_s, pass_s, fail_s, timeout_s, busy_next_s;

  assign csum_s      = sum_r + rx_data;
  // The idle timer only runs inside a frame; a byte in the expiry cycle wins.
  assign timeout_s   = busy_r && !rx_valid && (timer_r == TIMER_LAST);
  assign busy_next_s = (state_next_s != S_IDLE) && (state_next_s != S_RUN);

  // Next-state and per-byte control decode
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    add_s        = 1'b0;
    write_s      = 1'b0;
    pass_s       = 1'b0;
    fail_s       = 1'b0;
    if (timeout_s) begin
      state_next_s = S_IDLE;
      fail_s       = 1'b1;
    end else if (rx_valid) begin
      case (state_r)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_next_s = S_CNT_HI;
            start_s      = 1'b1;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_CNT_HI: begin
          add_s        = 1'b1;
          state_next_s = S_CNT_LO;
        end
        S_CNT_LO: begin
          add_s = 1'b1;
          if ({count_r[15:8], rx_data} == 16'h0000) begin
            state_next_s = S_CSUM;
          end else begin
            state_next_s = S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          add_s        = 1'b1;
          state_next_s = S_DATA_LO;
        end
        S_DATA_LO: begin
          add_s   = 1'b1;
          write_s = 1'b1;
          // words_loaded still holds the count before this word
          if (words_loaded_r + 16'd1 == count_r) begin
            state_next_s = S_CSUM;
          end else begin
            state_next_s = S_DATA_HI;
          end
        end
        S_CSUM: begin
          if (csum_s == 8'h00) begin
            state_next_s = S_RUN;
            pass_s       = 1'b1;
          end else begin
            state_next_s = S_IDLE;
            fail_s       = 1'b1;
          end
        end
        S_RUN: begin
          state_next_s = S_RUN;
        end
        default: begin
          state_next_s = S_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_next_s;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_we_r        <= 1'b0;
      ld_addr_r      <= BASE_ADDR;
      ld_wdata_r     <= 16'h0000;
      cpu_reset_n_r  <= 1'b0;
      busy_r         <= 1'b0;
      error_r        <= 1'b0;
      words_loaded_r <= 16'h0000;
      count_r        <= 16'h0000;
      sum_r          <= 8'h00;
      hi_r           <= 8'h00;
      timer_r        <= '0;
    end else begin
      busy_r  <= busy_next_s;
      ld_we_r <= write_s;
      if (write_s) ld_wdata_r <= {hi_r, rx_data};
      if (rx_valid && (state_r == S_DATA_HI)) hi_r <= rx_data;
      if (rx_valid && (state_r == S_CNT_HI)) count_r[15:8] <= rx_data;
      if (rx_valid && (state_r == S_CNT_LO)) count_r[7:0] <= rx_data;
      // Address and word count advance the cycle after the write strobe
      if (start_s) begin
        ld_addr_r      <= BASE_ADDR;
        words_loaded_r <= 16'h0000;
      end else if (ld_we_r) begin
        ld_addr_r      <= ld_addr_r + 16'd1;
        words_loaded_r <= words_loaded_r + 16'd1;
      end
      if (start_s)    sum_r <= 8'h00;
      else if (add_s) sum_r <= sum_r + rx_data;
      if (start_s)     error_r <= 1'b0;
      else if (fail_s) error_r <= 1'b1;
      if (pass_s) cpu_reset_n_r <= 1'b1;
      if (!busy_next_s || rx_valid) timer_r <= '0;
      else                          timer_r <= timer_r + TW'(1);
    end
  end

  assign ld_we        = ld_we_r;
  assign ld_addr      = ld_addr_r;
  assign ld_wdata     = ld_wdata_r;
  assign cpu_reset_n  = cpu_reset_n_r;
  assign busy         = busy_r;
  assign error        = error_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_zimbo_boot_loader.sv
// Randomized bench for zimbo_boot_loader: two instances (base 0x0000 and 0xFFFF) share
// one byte stream; results are compared against a position-based frame parser model.
module tb_zimbo_boot_loader;

  localparam int TO = 16;
  localparam logic [7:0]  SYNC  = 8'hA5;
  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'hFFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic ld_we_o [2];
  logic [15:0] ld_addr_o [2];
  logic [15:0] ld_wdata_o [2];
  logic [15:0] words_o [2];
  logic cpu_rn_o [2];
  logic busy_o [2];
  logic error_o [2];

  always #5 clock = ~clock;

  zimbo_boot_loader #(.BASE_ADDR(BASE0), .TIMEOUT(TO), .SYNC_BYTE(SYNC)) dut0 (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ld_we(ld_we_o[0]), .ld_addr(ld_addr_o[0]), .ld_wdata(ld_wdata_o[0]),
    .cpu_reset_n(cpu_rn_o[0]), .busy(busy_o[0]), .error(error_o[0]),
    .words_loaded(words_o[0]));

  zimbo_boot_loader #(.BASE_ADDR(BASE1), .TIMEOUT(TO), .SYNC_BYTE(SYNC)) dut1 (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .ld_we(ld_we_o[1]), .ld_addr(ld_addr_o[1]), .ld_wdata(ld_wdata_o[1]),
    .cpu_reset_n(cpu_rn_o[1]), .busy(busy_o[1]), .error(error_o[1]),
    .words_loaded(words_o[1]));

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0]  stim_b [$];
  int          stim_g [$];
  int          played = 0;
  logic [31:0] obs0 [$];
  logic [31:0] obs1 [$];
  logic [31:0] m_wr [$];
  bit          m_run, m_err, m_busy;
  logic [15:0] m_words;

  // Write monitor: records {addr, data} for every strobe, sampled mid-cycle
  always @(negedge clock) begin
    if (ld_we_o[0] === 1'b1) obs0.push_back({ld_addr_o[0], ld_wdata_o[0]});
    if (ld_we_o[1] === 1'b1) obs1.push_back({ld_addr_o[1], ld_wdata_o[1]});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] base_of(input int u);
    return (u == 0) ? BASE0 : BASE1;
  endfunction

  // Reference: walk the byte stream by position within each frame.
  task automatic model(input logic [15:0] base);
    int i, k, cnt;
    logic [7:0] sum, hi, b;
    logic [15:0] a;
    m_wr.delete();
    m_run = 0; m_err = 0; m_busy = 0; m_words = 16'h0000;
    i = 0; hi = 8'h00;
    while (i < stim_b.size() && !m_run) begin
      if (stim_b[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      m_err = 0; m_words = 16'h0000; sum = 8'h00; cnt = 0; k = 0; m_busy = 1;
      while (m_busy) begin
        if (i >= stim_b.size()) break;
        if (stim_g[i] >= TO) begin
          m_err = 1; m_busy = 0;
          break;
        end
        b = stim_b[i]; i++; k++;
        if (k == 1) begin
          cnt = int'(b) * 256; sum = sum + b;
        end else if (k == 2) begin
          cnt = cnt + int'(b); sum = sum + b;
        end else if (k == 3 + 2 * cnt) begin
          m_busy = 0;
          if (8'(sum + b) == 8'h00) m_run = 1;
          else m_err = 1;
        end else begin
          sum = sum + b;
          if (k % 2 == 1) hi = b;
          else begin
            a = base + m_words;
            m_wr.push_back({a, hi, b});
            m_words = m_words + 16'd1;
          end
        end
      end
    end
  endtask

  task automatic add(input logic [7:0] b, input int gap);
    stim_b.push_back(b);
    stim_g.push_back(gap);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clock); #1;
    end
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic play();
    while (played < stim_b.size()) begin
      send_byte(stim_b[played], stim_g[played]);
      played++;
    end
  endtask

  task automatic check_reset(input string tag);
    for (int u = 0; u < 2; u++) begin
      check_val({tag, "_we"}, ld_we_o[u], 1'b0);
      check_val({tag, "_addr"}, ld_addr_o[u], base_of(u));
      check_val({tag, "_wdata"}, ld_wdata_o[u], 16'h0000);
      check_val({tag, "_cpurn"}, cpu_rn_o[u], 1'b0);
      check_val({tag, "_busy"}, busy_o[u], 1'b0);
      check_val({tag, "_err"}, error_o[u], 1'b0);
      check_val({tag, "_words"}, words_o[u], 16'h0000);
    end
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset(tag);
    @(posedge clock); #1;
    reset = 1'b0;
    stim_b.delete(); stim_g.delete(); played = 0;
    obs0.delete(); obs1.delete();
  endtask

  task automatic verify(input string tag);
    logic [31:0] q [$];
    logic [15:0] a;
    repeat (4) begin
      @(posedge clock); #1;
    end
    for (int u = 0; u < 2; u++) begin
      model(base_of(u));
      if (u == 0) q = obs0;
      else q = obs1;
      check_val({tag, "_nwr"}, q.size(), m_wr.size());
      for (int j = 0; j < m_wr.size() && j < q.size(); j++)
        check_val({tag, "_wr"}, q[j], m_wr[j]);
      a = base_of(u) + m_words;
      check_val({tag, "_cpurn"}, cpu_rn_o[u], m_run);
      check_val({tag, "_err"}, error_o[u], m_err);
      check_val({tag, "_busy"}, busy_o[u], m_busy);
      check_val({tag, "_words"}, words_o[u], m_words);
      check_val({tag, "_addr"}, ld_addr_o[u], a);
    end
  endtask

  task automatic add_frame_a(input logic [7:0] cs);
    logic [7:0] fa [7];
    fa = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    foreach (fa[j]) add(fa[j], 0);
    add(cs, 0);
  endtask

  function automatic int rgap();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 6) return 0;
    if (r < 8) return 1;
    if (r < 10) return 2;
    if (r == 10) return TO - 1;
    return TO + int'($urandom_range(0, 2));
  endfunction

  task automatic add_rand_frame();
    int n;
    logic [7:0] b, sum;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      add(b, int'($urandom_range(0, 2)));
    end
    n = int'($urandom_range(0, 4));
    add(SYNC, rgap());
    add(8'h00, rgap());
    add(8'(n), rgap());
    sum = 8'(n);
    for (int j = 0; j < 2 * n; j++) begin
      b = 8'($urandom);
      sum = sum + b;
      add(b, rgap());
    end
    b = 8'h00 - sum;
    if ($urandom_range(0, 3) == 0) b = b + 8'($urandom_range(1, 255));
    add(b, rgap());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    apply_reset("por");

    add_frame_a(8'h40);
    play();
    check_val("csum_edge_cpurn0", cpu_rn_o[0], 1'b1);
    check_val("csum_edge_cpurn1", cpu_rn_o[1], 1'b1);
    verify("frame_a");

    apply_reset("rst_run");
    add_frame_a(8'h41);
    play();
    check_val("badcs_edge_err0", error_o[0], 1'b1);
    verify("bad_csum");
    add(8'hA5, 0); add(8'h00, 0); add(8'h01, 0); add(8'h55, 0); add(8'h66, 0); add(8'h44, 0);
    play();
    verify("good_after_bad");

    apply_reset("rst2");
    add(8'h00, 0); add(8'hFF, 1); add(8'h12, 0);
    add(8'hA5, 0); add(8'h00, 0); add(8'h00, 0); add(8'h00, 0);
    play();
    verify("n_zero");

    apply_reset("rst3");
    add(8'hA5, 0); add(8'h00, 0); add(8'h01, 0); add(8'h12, 0); add(8'h34, TO);
    play();
    verify("timeout");

    apply_reset("rst4");
    add(8'hA5, 0); add(8'h00, 0); add(8'h01, 0); add(8'h12, 0); add(8'h34, TO - 1); add(8'hB9, 0);
    play();
    verify("just_alive");

    apply_reset("rst5");
    add(8'hA5, 0); add(8'h00, 0); add(8'h02, 0); add(8'h12, 0);
    play();
    apply_reset("rst_data_lo");
    add_frame_a(8'h40);
    play();
    verify("after_mid_reset");

    for (int it = 0; it < 10; it++) begin
      apply_reset("rst_rand");
      add_rand_frame();
      if ($urandom_range(0, 1) == 1) add_rand_frame();
      play();
      verify("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
